// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative MIPS multiply/divide unit with private HI/LO registers.
// Optional MULDIV_FAST_MULT_EN: single-cycle combinational MULT/MULTU; divides stay iterative.
module ex_muldiv_unit #(
  parameter logic [31:0] DIVZERO_QUOTIENT = 32'hFFFFFFFF,
  parameter int          ITER_CYCLES      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] EX_ReadData1,
  input  logic [31:0] EX_ReadData2,
  input  logic [31:0] EX_Instruction,
  output logic [31:0] EX_HiLoData,
  output logic        EX_HiLoSelect,
  output logic        MulDiv_Busy,
  output logic        MulDiv_Stall
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, isdiv_q, isdiv_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [5:0]  funct_s;
  logic        op0_s, is_mul_s, is_div_s, is_mfhi_s, is_mflo_s, is_mthi_s, is_mtlo_s;
  logic        hilo_instr_s, signed_s, sgn1_s, sgn2_s;
  logic [31:0] abs1_s, abs2_s;
  logic [32:0] sum_s, shifted_s, diff_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quo_fix_s, rem_fix_s;

  assign funct_s   = EX_Instruction[5:0];
  assign op0_s     = (EX_Instruction[31:26] == 6'h00);
  assign is_mul_s  = op0_s && (funct_s == 6'h18 || funct_s == 6'h19);
  assign is_div_s  = op0_s && (funct_s == 6'h1A || funct_s == 6'h1B);
  assign is_mfhi_s = op0_s && (funct_s == 6'h10);
  assign is_mthi_s = op0_s && (funct_s == 6'h11);
  assign is_mflo_s = op0_s && (funct_s == 6'h12);
  assign is_mtlo_s = op0_s && (funct_s == 6'h13);
  assign hilo_instr_s = is_mul_s | is_div_s | is_mfhi_s | is_mflo_s | is_mthi_s | is_mtlo_s;

  // Even funct codes (MULT, DIV) are the signed variants.
  assign signed_s = ~funct_s[0];
  assign sgn1_s   = signed_s & EX_ReadData1[31];
  assign sgn2_s   = signed_s & EX_ReadData2[31];
  assign abs1_s   = sgn1_s ? (32'd0 - EX_ReadData1) : EX_ReadData1;
  assign abs2_s   = sgn2_s ? (32'd0 - EX_ReadData2) : EX_ReadData2;

  assign sum_s      = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign shifted_s  = {work_q[63:32], work_q[31]};
  assign diff_s     = shifted_s - {1'b0, opnd_q};
  assign prod_fix_s = neg_q ? (64'd0 - work_q) : work_q;
  assign quo_fix_s  = neg_q ? (32'd0 - work_q[31:0]) : work_q[31:0];
  assign rem_fix_s  = rneg_q ? (32'd0 - work_q[63:32]) : work_q[63:32];

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] prod_s;
  assign prod_s = {{32{sgn1_s}}, EX_ReadData1} * {{32{sgn2_s}}, EX_ReadData2};
`endif

  // Next-state logic for the FSM, datapath and HI/LO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    isdiv_d = isdiv_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (is_mul_s) begin
`ifdef MULDIV_FAST_MULT_EN
          {hi_d, lo_d} = prod_s;
`else
          cnt_d   = ITER_CYCLES[5:0];
          work_d  = {32'd0, abs2_s};
          opnd_d  = abs1_s;
          neg_d   = sgn1_s ^ sgn2_s;
          rneg_d  = 1'b0;
          dz_d    = 1'b0;
          isdiv_d = 1'b0;
          state_d = S_MUL;
`endif
        end else if (is_div_s) begin
          cnt_d   = ITER_CYCLES[5:0];
          work_d  = {32'd0, abs1_s};
          opnd_d  = abs2_s;
          neg_d   = sgn1_s ^ sgn2_s;
          rneg_d  = sgn1_s;
          dz_d    = (EX_ReadData2 == 32'd0);
          isdiv_d = 1'b1;
          state_d = S_DIV;
        end else if (is_mthi_s) begin
          hi_d = EX_ReadData1;
        end else if (is_mtlo_s) begin
          lo_d = EX_ReadData1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        work_d = {sum_s, work_q[31:1]};
        cnt_d  = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_FIX;
        else               state_d = S_MUL;
      end
      S_DIV: begin
        // A zero divisor always "subtracts", leaving the dividend magnitude as remainder.
        if (!diff_s[32]) work_d = {diff_s[31:0], work_q[30:0], 1'b1};
        else             work_d = {shifted_s[31:0], work_q[30:0], 1'b0};
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_FIX;
        else               state_d = S_DIV;
      end
      S_FIX: begin
        if (isdiv_q) begin
          hi_d = rem_fix_s;
          lo_d = dz_q ? DIVZERO_QUOTIENT : quo_fix_s;
        end else begin
          {hi_d, lo_d} = prod_fix_s;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      work_q  <= 64'd0;
      opnd_q  <= 32'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      isdiv_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      isdiv_q <= isdiv_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign MulDiv_Busy   = (state_q != S_IDLE);
  assign MulDiv_Stall  = MulDiv_Busy & hilo_instr_s;
  assign EX_HiLoSelect = is_mfhi_s | is_mflo_s;
  assign EX_HiLoData   = is_mfhi_s ? hi_q : (is_mflo_s ? lo_q : 32'd0);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed scoreboard bench for ex_muldiv_unit; expectations come from native SV arithmetic.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] EX_ReadData1, EX_ReadData2, EX_Instruction;
  logic [31:0] EX_HiLoData;
  logic        EX_HiLoSelect, MulDiv_Busy, MulDiv_Stall;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;
  logic [31:0] sb_q[$];
  int st, n;

  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD = 6'h20;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk(clk), .reset(reset),
    .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Instruction(EX_Instruction),
    .EX_HiLoData(EX_HiLoData), .EX_HiLoSelect(EX_HiLoSelect),
    .MulDiv_Busy(MulDiv_Busy), .MulDiv_Stall(MulDiv_Stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      F_MULT:  begin p = longint'(sa) * longint'(sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      F_MULTU: begin p = {32'd0, a} * {32'd0, b};     m_hi = p[63:32]; m_lo = p[31:0]; end
      F_DIV: begin
        if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFFFFFF; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin m_hi = 32'd0; m_lo = 32'h80000000; end
        else begin m_lo = sa / sb; m_hi = sa % sb; end
      end
      F_DIVU: begin
        if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFFFFFF; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      F_MTHI: m_hi = a;
      F_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Drive one instruction into EX, hold it while stalled, return the stall cycle count.
  task automatic issue(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, output int stalls);
    logic [31:0] exp;
    if (f == F_MFHI || f == F_MFLO) sb_q.push_back((f == F_MFHI) ? m_hi : m_lo);
    EX_Instruction = {26'd0, f};
    EX_ReadData1 = a;
    EX_ReadData2 = b;
    stalls = 0;
    @(negedge clk);
    while (MulDiv_Stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    check({tag, "_stall_bound"}, 64'(stalls < 200), 64'd1);
    if (f == F_MFHI || f == F_MFLO) begin
      exp = sb_q.pop_front();
      check({tag, "_data"}, 64'(EX_HiLoData), 64'(exp));
      check({tag, "_sel"}, 64'(EX_HiLoSelect), 64'd1);
    end else if (f == F_ADD) begin
      check({tag, "_sel"}, 64'(EX_HiLoSelect), 64'd0);
      check({tag, "_data"}, 64'(EX_HiLoData), 64'd0);
    end
    model_op(f, a, b);
    @(posedge clk);
    #1;
    EX_Instruction = 32'd0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (MulDiv_Busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    EX_Instruction = 32'd0;
    EX_ReadData1 = 32'd0;
    EX_ReadData2 = 32'd0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(MulDiv_Busy), 64'd0);
    check("rst_stall", 64'(MulDiv_Stall), 64'd0);
    check("rst_data", 64'(EX_HiLoData), 64'd0);
    check("rst_sel", 64'(EX_HiLoSelect), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    issue("multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, st);
    wait_idle(n);
    check("multu_busy_cycles", 64'(n), 64'(MUL_BUSY));
    issue("multu_hi", F_MFHI, 32'd0, 32'd0, st);
    issue("multu_lo", F_MFLO, 32'd0, 32'd0, st);

    issue("mult", F_MULT, 32'hFFFFFFFD, 32'd7, st);
    issue("mult_hi", F_MFHI, 32'd0, 32'd0, st);
    check("mult_hi_stalls", 64'(st), 64'(MUL_BUSY));
    issue("mult_lo", F_MFLO, 32'd0, 32'd0, st);

    issue("div", F_DIV, 32'hFFFFFFF9, 32'd2, st);
    issue("div_lo", F_MFLO, 32'd0, 32'd0, st);
    check("div_lo_stalls", 64'(st), 64'(DIV_BUSY));
    issue("div_hi", F_MFHI, 32'd0, 32'd0, st);

    issue("divu0", F_DIVU, 32'd7, 32'd0, st);
    wait_idle(n);
    check("divu0_busy_cycles", 64'(n), 64'(DIV_BUSY));
    issue("divu0_hi", F_MFHI, 32'd0, 32'd0, st);
    issue("divu0_lo", F_MFLO, 32'd0, 32'd0, st);

    issue("div0s", F_DIV, 32'hFFFFFF00, 32'd0, st);
    issue("div0s_hi", F_MFHI, 32'd0, 32'd0, st);
    issue("div0s_lo", F_MFLO, 32'd0, 32'd0, st);

    issue("divovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, st);
    issue("divovf_lo", F_MFLO, 32'd0, 32'd0, st);
    issue("divovf_hi", F_MFHI, 32'd0, 32'd0, st);

    issue("div_neg_divisor", F_DIV, 32'd7, 32'hFFFFFFFE, st);
    issue("divnd_lo", F_MFLO, 32'd0, 32'd0, st);
    issue("divnd_hi", F_MFHI, 32'd0, 32'd0, st);

    issue("mult56", F_MULT, 32'd5, 32'd6, st);
    issue("mult56_lo", F_MFLO, 32'd0, 32'd0, st);
    check("mult56_lo_stalls", 64'(st), 64'(MUL_BUSY));

    issue("mult56b", F_MULT, 32'd5, 32'd6, st);
    issue("add", F_ADD, 32'd1, 32'd2, st);
    check("add_stalls", 64'(st), 64'd0);
    issue("mult56b_lo", F_MFLO, 32'd0, 32'd0, st);
    check("mult56b_lo_stalls", 64'(st), 64'((MUL_BUSY > 0) ? MUL_BUSY - 1 : 0));

    issue("mthi", F_MTHI, 32'h00001234, 32'd0, st);
    issue("mthi_hi", F_MFHI, 32'd0, 32'd0, st);
    check("mthi_hi_stalls", 64'(st), 64'd0);

    issue("divu_a", F_DIVU, 32'd100, 32'd7, st);
    issue("multu_after_div", F_MULTU, 32'd3, 32'd4, st);
    check("multu_after_div_stalls", 64'(st), 64'(DIV_BUSY));
    issue("mad_lo", F_MFLO, 32'd0, 32'd0, st);
    issue("mad_hi", F_MFHI, 32'd0, 32'd0, st);

    issue("divu_b", F_DIVU, 32'd100, 32'd7, st);
    issue("mtlo_busy", F_MTLO, 32'h0000ABCD, 32'd0, st);
    check("mtlo_busy_stalls", 64'(st), 64'(DIV_BUSY));
    issue("mtlo_lo", F_MFLO, 32'd0, 32'd0, st);
    issue("mtlo_hi", F_MFHI, 32'd0, 32'd0, st);

    issue("divu_rst", F_DIVU, 32'd1000, 32'd3, st);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    EX_Instruction = {26'd0, F_MFHI};
    @(negedge clk);
    check("rst_mid_busy_before", 64'(MulDiv_Busy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", 64'(MulDiv_Busy), 64'd0);
    check("rst_mid_stall", 64'(MulDiv_Stall), 64'd0);
    check("rst_mid_data", 64'(EX_HiLoData), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    EX_Instruction = 32'd0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    issue("post_rst_hi", F_MFHI, 32'd0, 32'd0, st);
    check("post_rst_hi_stalls", 64'(st), 64'd0);
    issue("post_rst_lo", F_MFLO, 32'd0, 32'd0, st);
    repeat (3) @(posedge clk);
    issue("late_hi", F_MFHI, 32'd0, 32'd0, st);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage multiply/divide unit.
- Consumes the ID/EX register outputs (operands and instruction word) alongside the ALU.
- Executes MIPS MULT, MULTU, DIV, DIVU iteratively into private HI/LO registers, and services MFHI, MFLO, MTHI, MTLO.
- Drives a stall to the hazard logic so the PC, IF/ID and ID/EX hold while a dependent instruction waits in EX.

Parameters:
- DIVZERO_QUOTIENT, 32'hFFFFFFFF, value written to LO on divide by zero.
- ITER_CYCLES, 32, busy cycles per iterative operation; one quotient/product bit per cycle; only 32 is supported.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- EX_ReadData1  input  32  rs operand: multiplicand or dividend.
- EX_ReadData2  input  32  rt operand: multiplier or divisor.
- EX_Instruction  input  32  instruction currently in EX; decoded when opcode = 6'h00.
- EX_HiLoData  output  32  HI for MFHI, LO for MFLO, 0 otherwise.
- EX_HiLoSelect  output  1  1 when the EX instruction is MFHI/MFLO; drives the EX result mux.
- MulDiv_Busy  output  1  iterative operation in progress.
- MulDiv_Stall  output  1  hold request to PC, IF/ID and ID/EX.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-low on port `reset`.
- Reset (`reset` == 0 at a rising edge):
  - HI, LO, iteration counter, working registers and FSM are cleared; FSM goes to IDLE.
  - MulDiv_Busy = 0, MulDiv_Stall = 0, EX_HiLoData = 0, EX_HiLoSelect = 0.
  - Reset mid-operation aborts the operation; no partial result reaches HI/LO.
- Decode (opcode 0, funct field):
  - 18 = MULT, 19 = MULTU, 1A = DIV, 1B = DIVU.
  - 10 = MFHI, 12 = MFLO, 11 = MTHI, 13 = MTLO.
  - Any other instruction is ignored by this unit.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE: a mult/div in EX is accepted at the edge. Operand magnitudes are latched; signs are latched for MULT/DIV. Counter is loaded with ITER_CYCLES. Next state is MUL or DIV.
  - MUL: shift-add, one bit per cycle.
  - DIV: restoring divide, one bit per cycle.
  - In MUL/DIV the counter decrements each cycle; at 1 the next state is FIX.
  - FIX: sign correction is applied, HI/LO are written at the edge, next state is IDLE.
- Timing:
  - Accept edge E.
  - MulDiv_Busy = 1 for the ITER_CYCLES + 1 cycles after E.
  - HI/LO are updated at the edge ending FIX.
  - Busy is low in the following cycle.
- Stall:
  - MulDiv_Stall = MulDiv_Busy AND (EX instruction is any of the 8 HI/LO instructions).
  - Stall is combinational.
  - The accepting cycle itself never stalls, so the accepted instruction leaves EX at E and cannot be re-accepted.
  - A stalled mult/div is accepted in the first cycle Busy is low.
- Non-HI/LO instructions flow freely while Busy.
- MFHI/MFLO:
  - EX_HiLoSelect = 1.
  - EX_HiLoData = current HI/LO, combinational.
  - When Busy is low, the result written in FIX is already visible.
- MTHI/MTLO write EX_ReadData1 into HI/LO at the edge, only when Busy = 0.
- Signed arithmetic:
  - MULT: 64-bit product sign = sign1 XOR sign2.
  - DIV: quotient sign = sign1 XOR sign2; remainder takes the dividend's sign; LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (DIV or DIVU):
  - Runs the full latency.
  - HI = dividend (unmodified bits), LO = DIVZERO_QUOTIENT.
- Unsigned operations never apply sign correction.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU use a combinational 32x32 product; HI/LO are written at the accept edge.
  - FSM stays IDLE and Busy never asserts for multiplies.
  - DIV/DIVU are unchanged.
- Undefined: iterative multiply as specified above.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Busy high 33 cycles; then HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT -3 x 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 7 / 0 -> HI = 7, LO = 0xFFFFFFFF.
- DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- MULT 5 x 6 immediately followed by MFLO:
  - Stall = 1 for 33 cycles.
  - In the first cycle Stall = 0: EX_HiLoSelect = 1, EX_HiLoData = 30.
  - An ADD following the MULT is never stalled.
- MTHI 0x00001234 when idle, then MFHI -> EX_HiLoData = 0x00001234.
- MTLO issued while Busy -> stalls; LO is not written until Busy falls.
- Reset low at busy cycle 10 -> next edge: Busy = 0, Stall = 0, HI = LO = 0; a later MFHI returns 0.
- MULDIV_FAST_MULT_EN defined, MULT 5 x 6 then MFLO -> no stall; EX_HiLoData = 30 one cycle after accept.
